// File: rtl/pmem_arbiter.sv
// ---------------------------------------------------------------------------
// pmem_arbiter
//   Shares one physical-memory port between the I-cache miss path and the
//   D-cache miss/writeback path. One line transaction is in flight at a time.
//   The returned line is captured in a buffer, and a one-cycle completion
//   pulse is steered back to the requester that won.
//
//   Optional feature macro: PMEM_ARB_RR_EN
//     defined   : round-robin when I and D request in the same cycle
//                 (the side that was not granted last wins)
//     undefined : fixed priority, D always beats I (a D miss stalls the
//                 whole pipeline)
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   i_pmem_read/address          I-cache line read request (level)
//   i_pmem_resp/rdata            I-cache completion pulse and line
//   d_pmem_read/write/address    D-cache read / writeback request (level)
//   d_pmem_wdata                 D-cache writeback line
//   d_pmem_resp/rdata            D-cache completion pulse and line
//   pmem_read/write/address/     registered physical memory request
//   pmem_wdata
//   pmem_resp/rdata              physical memory completion and read line
// ---------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D,
    ST_RESP_I,
    ST_RESP_D,
    ST_GAP
  } state_t;

  state_t              state_q, state_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                d_req;
  logic                grant_i;
  logic                grant_d;
`ifdef PMEM_ARB_RR_EN
  // 1 = D was granted last, 0 = I was granted last (reset value: I)
  logic                last_d_q, last_d_d;
`endif

  assign d_req = d_pmem_read | d_pmem_write;

  // Grant decision, only meaningful in IDLE
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == ST_IDLE) begin
`ifdef PMEM_ARB_RR_EN
      if (d_req && i_pmem_read) begin
        if (last_d_q) grant_i = 1'b1;
        else          grant_d = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end else if (i_pmem_read) begin
        grant_i = 1'b1;
      end
`else
      if (d_req)            grant_d = 1'b1;
      else if (i_pmem_read) grant_i = 1'b1;
`endif
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;
`ifdef PMEM_ARB_RR_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d = ST_BUSY_D;
          // Simultaneous read+write from D is illegal; the write wins.
          wr_d    = d_pmem_write;
          rd_d    = ~d_pmem_write;
          addr_d  = d_pmem_address;
          wdata_d = d_pmem_wdata;
`ifdef PMEM_ARB_RR_EN
          last_d_d = 1'b1;
`endif
        end else if (grant_i) begin
          state_d = ST_BUSY_I;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          addr_d  = i_pmem_address;
          wdata_d = '0;
`ifdef PMEM_ARB_RR_EN
          last_d_d = 1'b0;
`endif
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        // No abort: the transaction runs to completion even if the
        // requester has dropped its request meanwhile.
        if (pmem_resp) begin
          line_d  = pmem_rdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = (state_q == ST_BUSY_I) ? ST_RESP_I : ST_RESP_D;
        end
      end
      ST_RESP_I, ST_RESP_D: state_d = ST_GAP;
      // One dead cycle so the served requester can deassert before the
      // next sampling point.
      ST_GAP:               state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
`ifdef PMEM_ARB_RR_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
`ifdef PMEM_ARB_RR_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_pmem_resp  = (state_q == ST_RESP_I);
  assign d_pmem_resp  = (state_q == ST_RESP_D);
  assign i_pmem_rdata = line_q;
  assign d_pmem_rdata = line_q;

endmodule
